// File: rtl/sad_csa_accum_pipe_if.sv
// Beat-in / block-result bundle for sad_csa_accum_pipe. Lane i of pix_a/pix_b is [i*PIX_W +: PIX_W].
// Handshake: a transfer happens on a rising clk edge where valid & ready are both high; the source
// holds its payload stable while valid is high and not yet accepted; ready may depend on valid.
interface sad_csa_accum_pipe_if #(
  parameter int N_PIX = 8,
  parameter int PIX_W = 8,
  parameter int ACC_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [N_PIX*PIX_W-1:0] pix_a;
  logic [N_PIX*PIX_W-1:0] pix_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       sad;
  logic                   sad_ovf;

  modport master (
    output in_valid, in_last, pix_a, pix_b, out_ready,
    input  in_ready, out_valid, sad, sad_ovf
  );

  modport slave (
    input  in_valid, in_last, pix_a, pix_b, out_ready,
    output in_ready, out_valid, sad, sad_ovf
  );
endinterface

// File: rtl/sad_csa_accum_pipe.sv
// Three-stage SAD engine: |a-b| per lane, 4:2 compressor tree to two carry-save rows, block accumulate.
// Define SAD_SAT_EN to clamp overflowing blocks to 2^ACC_W-1 and flag them on sad_ovf; otherwise wrap.
module sad_csa_accum_pipe #(
  parameter int N_PIX = 8,
  parameter int PIX_W = 8,
  parameter int ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sad_csa_accum_pipe_if.slave  bus,
  output logic                 o_dbg_state
);

  localparam int LVLS = $clog2(N_PIX) - 1;
`ifdef SAD_SAT_EN
  // Rows must hold the exact beat total so a carry out of ACC_W is never lost before the final add.
  localparam int TREE_W = PIX_W + $clog2(N_PIX);
  localparam int ROW_W  = (TREE_W > ACC_W) ? TREE_W : ACC_W;
  localparam int SUM_W  = ROW_W + 1;
`else
  localparam int ROW_W  = ACC_W;
`endif

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_stall;

  logic [PIX_W-1:0] w_diff    [N_PIX];
  logic             r_s1_valid;
  logic             r_s1_last;
  logic [PIX_W-1:0] r_s1_diff [N_PIX];

  logic [ROW_W-1:0] w_rows    [N_PIX];
  logic [ROW_W-1:0] w_t_s1;
  logic [ROW_W-1:0] w_t_c1;
  logic [ROW_W-1:0] w_t_s2;
  logic [ROW_W-1:0] w_t_c2;
  logic             r_s2_valid;
  logic             r_s2_last;
  logic [ROW_W-1:0] r_s2_sum;
  logic [ROW_W-1:0] r_s2_carry;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sad;
  logic [ACC_W-1:0] w_result;

  // Stage 1: unsigned absolute difference per lane
  always_comb begin
    for (int i = 0; i < N_PIX; i++) begin
      if (bus.pix_a[i*PIX_W +: PIX_W] >= bus.pix_b[i*PIX_W +: PIX_W])
        w_diff[i] = bus.pix_a[i*PIX_W +: PIX_W] - bus.pix_b[i*PIX_W +: PIX_W];
      else
        w_diff[i] = bus.pix_b[i*PIX_W +: PIX_W] - bus.pix_a[i*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int i = 0; i < N_PIX; i++) r_s1_diff[i] <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= bus.in_valid;
      r_s1_last  <= bus.in_last;
      r_s1_diff  <= w_diff;
    end
  end

  // Stage 2: each level folds groups of four rows into two with a 4:2 compressor (two chained 3:2
  // CSAs), halving the row count in place until rows 0 and 1 carry the sum and carry vectors.
  always_comb begin
    w_t_s1 = '0;
    w_t_c1 = '0;
    w_t_s2 = '0;
    w_t_c2 = '0;
    for (int i = 0; i < N_PIX; i++) w_rows[i] = ROW_W'(r_s1_diff[i]);
    for (int l = 0; l < LVLS; l++) begin
      for (int g = 0; g < N_PIX / 4; g++) begin
        if (g < (N_PIX >> (l + 2))) begin
          w_t_s1 = w_rows[4*g] ^ w_rows[4*g+1] ^ w_rows[4*g+2];
          w_t_c1 = ((w_rows[4*g] & w_rows[4*g+1]) | (w_rows[4*g] & w_rows[4*g+2]) |
                    (w_rows[4*g+1] & w_rows[4*g+2])) << 1;
          w_t_s2 = w_t_s1 ^ w_t_c1 ^ w_rows[4*g+3];
          w_t_c2 = ((w_t_s1 & w_t_c1) | (w_t_s1 & w_rows[4*g+3]) |
                    (w_t_c1 & w_rows[4*g+3])) << 1;
          w_rows[2*g]   = w_t_s2;
          w_rows[2*g+1] = w_t_c2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_carry <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_sum   <= w_rows[0];
      r_s2_carry <= w_rows[1];
    end
  end

  // Stage 3: final carry-propagate add into the block accumulator
`ifdef SAD_SAT_EN
  logic [SUM_W-1:0] w_total;
  logic             w_carry_out;
  logic             r_acc_ovf;
  logic             r_sad_ovf;

  assign w_total     = SUM_W'(r_acc) + SUM_W'(r_s2_sum) + SUM_W'(r_s2_carry);
  assign w_carry_out = |w_total[SUM_W-1:ACC_W];
  assign w_result    = w_carry_out ? {ACC_W{1'b1}} : w_total[ACC_W-1:0];
`else
  assign w_result    = r_acc + r_s2_sum + r_s2_carry;
`endif

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ACCUM: begin
        if (r_s2_valid && r_s2_last) w_state_next = HOLD;
      end
      HOLD: begin
        w_stall = !bus.out_ready;
        if (bus.out_ready && !(r_s2_valid && r_s2_last)) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_sad   <= '0;
`ifdef SAD_SAT_EN
      r_acc_ovf <= 1'b0;
      r_sad_ovf <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (!w_stall) begin
        if (r_s2_valid && r_s2_last) begin
          r_sad <= w_result;
          r_acc <= '0;
`ifdef SAD_SAT_EN
          r_sad_ovf <= r_acc_ovf | w_carry_out;
          r_acc_ovf <= 1'b0;
`endif
        end else begin
          if (r_s2_valid) begin
            r_acc <= w_result;
`ifdef SAD_SAT_EN
            r_acc_ovf <= r_acc_ovf | w_carry_out;
`endif
          end
`ifdef SAD_SAT_EN
          // Unstalled in HOLD means the result is being consumed with no replacement.
          if (r_state == HOLD) r_sad_ovf <= 1'b0;
`endif
        end
      end
    end
  end

  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.sad       = r_sad;
`ifdef SAD_SAT_EN
  assign bus.sad_ovf   = r_sad_ovf;
`else
  assign bus.sad_ovf   = 1'b0;
`endif
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sad_csa_accum_pipe.sv
// Directed bench for sad_csa_accum_pipe: a default instance (ACC_W=16) and a narrow one (ACC_W=10)
// for overflow; expected values for the narrow one follow SAD_SAT_EN.
module tb_sad_csa_accum_pipe;
  localparam int N_PIX  = 8;
  localparam int PIX_W  = 8;
  localparam int ACC_W  = 16;
  localparam int ACC_W2 = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  logic dbg_state2;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sad_csa_accum_pipe_if #(.N_PIX(N_PIX), .PIX_W(PIX_W), .ACC_W(ACC_W))  bus ();
  sad_csa_accum_pipe_if #(.N_PIX(N_PIX), .PIX_W(PIX_W), .ACC_W(ACC_W2)) bus2 ();

  sad_csa_accum_pipe #(.N_PIX(N_PIX), .PIX_W(PIX_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  sad_csa_accum_pipe #(.N_PIX(N_PIX), .PIX_W(PIX_W), .ACC_W(ACC_W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .o_dbg_state(dbg_state2)
  );

  task automatic drive(input logic valid, input logic last, input logic [PIX_W-1:0] a,
                       input logic [PIX_W-1:0] b);
    bus.in_valid = valid;
    bus.in_last  = last;
    bus.pix_a    = {N_PIX{a}};
    bus.pix_b    = {N_PIX{b}};
  endtask

  task automatic drive2(input logic valid, input logic last, input logic [PIX_W-1:0] a,
                        input logic [PIX_W-1:0] b);
    bus2.in_valid = valid;
    bus2.in_last  = last;
    bus2.pix_a    = {N_PIX{a}};
    bus2.pix_b    = {N_PIX{b}};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    drive2(1'b0, 1'b0, '0, '0);
    bus.out_ready  = 1'b1;
    bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if (bus.sad !== '0) begin errors++; $display("FAIL reset_sad: got %0d want 0", bus.sad); end
    checks++; if (bus.sad_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", bus.sad_ovf); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0b want 0", dbg_state); end
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL reset2_out_valid: got %0b want 0", bus2.out_valid); end
  endtask

  task automatic test_single_beat();
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 8'd255, 8'd0);
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %0b want 1", bus.in_ready); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %0b want 0", bus.out_valid); end
    @(posedge clk); #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_t2_valid: got %0b want 0", bus.out_valid); end
    @(posedge clk); #2;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_t3_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.sad !== ACC_W'(2040)) begin errors++; $display("FAIL single_sad: got %0d want 2040", bus.sad); end
    checks++; if (bus.sad_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %0b want 0", bus.sad_ovf); end
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL single_state: got %0b want 1", dbg_state); end
    @(posedge clk); #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_t4_valid: got %0b want 0", bus.out_valid); end
  endtask

  // Lane a_i = 30*i, b = 100: diffs 100,70,40,10,20,50,80,110 -> 480
  task automatic test_lane_mix();
    @(posedge clk); #1;
    drive(1'b1, 1'b1, '0, 8'd100);
    for (int i = 0; i < N_PIX; i++) bus.pix_a[i*PIX_W +: PIX_W] = PIX_W'(i * 30);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk); #2;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mix_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.sad !== ACC_W'(480)) begin errors++; $display("FAIL mix_sad: got %0d want 480", bus.sad); end
  endtask

  task automatic test_multi_beat();
    int pulses;
    logic exp_v;
    pulses = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c < 2) drive(1'b1, 1'b0, 8'd10, 8'd3);
      else if (c == 2) drive(1'b1, 1'b0, 8'd3, 8'd10);
      else if (c == 3) drive(1'b1, 1'b1, 8'd3, 8'd10);
      else drive(1'b0, 1'b0, '0, '0);
      #1;
      exp_v = (c == 6);
      if (bus.out_valid === 1'b1) pulses++;
      checks++; if (bus.out_valid !== exp_v) begin errors++; $display("FAIL multi_valid_c%0d: got %0b want %0b", c, bus.out_valid, exp_v); end
      if (c == 6) begin
        checks++; if (bus.sad !== ACC_W'(224)) begin errors++; $display("FAIL multi_sad: got %0d want 224", bus.sad); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL multi_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_stall();
    int ta [4] = '{255, 2, 2, 2};
    int tb [4] = '{0, 5, 5, 5};
    int tl [4] = '{1, 0, 0, 1};
    int k, results, stall_cycles, model_acc, d;
    logic [ACC_W-1:0] exp;
    k = 0; results = 0; stall_cycles = 0; model_acc = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = !(cyc >= 3 && cyc <= 7);
      if (k < 4) drive(1'b1, tl[k] != 0, PIX_W'(ta[k]), PIX_W'(tb[k]));
      else drive(1'b0, 1'b0, '0, '0);
      #1;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready == 1'b0) begin
          stall_cycles++;
          checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_c%0d: got %0b want 0", cyc, bus.in_ready); end
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL stall_hold_c%0d: got %0d want none queued", cyc, bus.sad); end
          else if (bus.sad !== exp_q[0]) begin errors++; $display("FAIL stall_hold_c%0d: got %0d want %0d", cyc, bus.sad, exp_q[0]); end
        end else begin
          results++;
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL stall_result: got %0d want none queued", bus.sad); end
          else begin
            exp = exp_q.pop_front();
            if (bus.sad !== exp) begin errors++; $display("FAIL stall_result: got %0d want %0d", bus.sad, exp); end
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        d = (ta[k] > tb[k]) ? ta[k] - tb[k] : tb[k] - ta[k];
        model_acc += N_PIX * d;
        if (tl[k] != 0) begin
          exp_q.push_back(ACC_W'(model_acc));
          model_acc = 0;
        end
        k++;
      end
      if (k == 4 && results == 2) break;
    end
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    checks++; if (stall_cycles != 5) begin errors++; $display("FAIL stall_cycles: got %0d want 5", stall_cycles); end
    checks++; if (results != 2) begin errors++; $display("FAIL stall_results: got %0d want 2", results); end
    checks++; if (k != 4) begin errors++; $display("FAIL stall_beats: got %0d want 4", k); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_block();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'd200, 8'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'd200, 8'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.sad !== '0) begin errors++; $display("FAIL rst_mid_sad: got %0d want 0", bus.sad); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %0b want 1", bus.in_ready); end
    drive(1'b1, 1'b1, 8'd1, 8'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk); #2;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.sad !== ACC_W'(8)) begin errors++; $display("FAIL rst_fresh_sad: got %0d want 8", bus.sad); end
    @(posedge clk); #2;
  endtask

  task automatic test_overflow();
    int nb [4] = '{1, 1, 2, 3};
    int av [4] = '{255, 1, 80, 80};
`ifdef SAD_SAT_EN
    int es [4] = '{1023, 8, 1023, 1023};
    int eo [4] = '{1, 0, 1, 1};
`else
    int es [4] = '{1016, 8, 256, 896};
    int eo [4] = '{0, 0, 0, 0};
`endif
    bus2.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < nb[j]; k++) begin
        @(posedge clk); #1;
        drive2(1'b1, k == nb[j] - 1, PIX_W'(av[j]), 8'd0);
      end
      @(posedge clk); #1;
      drive2(1'b0, 1'b0, '0, '0);
      @(posedge clk);
      @(posedge clk); #2;
      checks++; if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_b%0d: got %0b want 1", j, bus2.out_valid); end
      checks++; if (bus2.sad !== ACC_W2'(es[j])) begin errors++; $display("FAIL ovf_sad_b%0d: got %0d want %0d", j, bus2.sad, es[j]); end
      checks++; if (bus2.sad_ovf !== eo[j][0]) begin errors++; $display("FAIL ovf_flag_b%0d: got %0b want %0b", j, bus2.sad_ovf, eo[j][0]); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_back_to_back();
    int j, results, last_cyc, gaps;
    logic [ACC_W-1:0] exp;
    j = 0; results = 0; last_cyc = -1; gaps = 0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (j < 6) drive(1'b1, 1'b1, PIX_W'(j * 10 + 5), PIX_W'(j));
      else drive(1'b0, 1'b0, '0, '0);
      #1;
      if (j < 6) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_c%0d: got %0b want 1", cyc, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1) begin
        if (last_cyc >= 0 && cyc != last_cyc + 1) gaps++;
        last_cyc = cyc;
        results++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_result: got %0d want none queued", bus.sad); end
        else begin
          exp = exp_q.pop_front();
          if (bus.sad !== exp) begin errors++; $display("FAIL b2b_result: got %0d want %0d", bus.sad, exp); end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ACC_W'(N_PIX * (9 * j + 5)));
        j++;
      end
      if (j == 6 && results == 6) break;
    end
    drive(1'b0, 1'b0, '0, '0);
    checks++; if (results != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", results); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_lane_mix();
    test_multi_beat();
    test_stall();
    test_reset_mid_block();
    test_overflow();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
